decode_ctrl: RTL and testbench

Multi-cycle instruction fetch/decode/writeback controller that sits directly upstream of the 8x16 register file. It fetches 16-bit instructions over a valid handshake, latches them, and drives the register-file controls: DEST, SRC0, SRC1, write enable and write-data select. It also drives ALU op and immediate to the datapath. It owns the program counter.

---
 rtl/decode_ctrl_pkg.sv | 63 ++++++
 rtl/decode_ctrl_field_decode.sv | 55 +++++
 rtl/decode_ctrl.sv | 148 ++++++++++++++
 tb/tb_decode_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_ctrl_pkg.sv
// Shared definitions for the fetch/decode/writeback controller: opcodes,
// FSM state encoding, instruction field positions and the decoded-field record.
package decode_ctrl_pkg;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RS0_MSB = 8;
  localparam int RS0_LSB = 6;
  localparam int RS1_MSB = 5;
  localparam int RS1_LSB = 3;
  localparam int FN_MSB  = 2;
  localparam int FN_LSB  = 0;
  localparam int IMM_MSB = 8;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ALU  = 4'h1;
  localparam logic [3:0] OP_LDI  = 4'h2;
  localparam logic [3:0] OP_MOV  = 4'h3;
  localparam logic [3:0] OP_HALT = 4'hF;

  // ALU function that forwards operand A unchanged (used by MOV).
  localparam logic [2:0] ALU_PASS_A = 3'b111;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WB     = 3'd3,
    HALT   = 3'd4
  } state_t;

  typedef struct packed {
    logic [2:0]  dest;
    logic [2:0]  src0;
    logic [2:0]  src1;
    logic [2:0]  alu_op;
    logic [15:0] imm;
    logic        wb_sel;
    logic        writes;
    logic        legal;
    logic        is_halt;
  } fields_t;

  // Decode of the all-zero IR (a NOP), which is what reset leaves in IR.
  localparam fields_t FIELDS_NOP = '{
    dest:    3'd0,
    src0:    3'd0,
    src1:    3'd0,
    alu_op:  3'd0,
    imm:     16'd0,
    wb_sel:  1'b0,
    writes:  1'b0,
    legal:   1'b1,
    is_halt: 1'b0
  };

  function automatic logic [15:0] zext_imm(input logic [IMM_MSB:0] f);
    return {{(15 - IMM_MSB){1'b0}}, f};
  endfunction

endpackage

// File: rtl/decode_ctrl_field_decode.sv
// Purely combinational instruction-word decode: register fields, ALU op,
// immediate, write-data select and the write/legal/halt classification.
module instr_field_decode
  import decode_ctrl_pkg::*;
(
  input  logic [15:0] ir,
  output logic [2:0]  dest,
  output logic [2:0]  src0,
  output logic [2:0]  src1,
  output logic [2:0]  alu_op,
  output logic [15:0] imm,
  output logic        wb_sel,
  output logic        writes,
  output logic        legal,
  output logic        is_halt
);

  logic [3:0] opcode;

  always_comb begin
    opcode  = ir[OPC_MSB:OPC_LSB];
    dest    = ir[RD_MSB:RD_LSB];
    src0    = ir[RS0_MSB:RS0_LSB];
    src1    = ir[RS1_MSB:RS1_LSB];
    imm     = zext_imm(ir[IMM_MSB:0]);
    alu_op  = 3'b000;
    wb_sel  = 1'b0;
    writes  = 1'b0;
    legal   = 1'b1;
    is_halt = 1'b0;
    case (opcode)
      OP_NOP: begin
      end
      OP_ALU: begin
        alu_op = ir[FN_MSB:FN_LSB];
        writes = 1'b1;
      end
      OP_LDI: begin
        wb_sel = 1'b1;
        writes = 1'b1;
      end
      OP_MOV: begin
        alu_op = ALU_PASS_A;
        writes = 1'b1;
      end
      OP_HALT: begin
        is_halt = 1'b1;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/decode_ctrl.sv
// Four-cycle fetch/decode/exec/writeback controller driving the 8x16 register
// file controls and the ALU op/immediate; owns the program counter.
module decode_ctrl
  import decode_ctrl_pkg::*;
#(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter bit          ILLEGAL_HALT = 1'b0
)
(
  input  logic        clk,
  input  logic        reset,
  output logic        instr_req,
  output logic [15:0] instr_addr,
  input  logic        instr_valid,
  input  logic [15:0] instr_data,
  output logic [2:0]  dest,
  output logic [2:0]  src0,
  output logic [2:0]  src1,
  output logic        w_en,
  output logic        wb_sel,
  output logic [2:0]  alu_op,
  output logic [15:0] imm,
  output logic [15:0] pc,
  output logic        halted,
  output logic        illegal
);

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  fields_t     fld_q, fld_d;
  logic        w_en_q, w_en_d;
  logic        illegal_q, illegal_d;
  logic        halted_q, halted_d;
  logic        instr_req_q, instr_req_d;
  logic        load;

  logic [2:0]  dec_dest, dec_src0, dec_src1, dec_alu_op;
  logic [15:0] dec_imm;
  logic        dec_wb_sel, dec_writes, dec_legal, dec_is_halt;

  // Decoding the next IR value lets the field registers load on the same edge
  // as IR, so the fields are already valid in the DECODE cycle.
  instr_field_decode u_field_decode (
    .ir      (ir_d),
    .dest    (dec_dest),
    .src0    (dec_src0),
    .src1    (dec_src1),
    .alu_op  (dec_alu_op),
    .imm     (dec_imm),
    .wb_sel  (dec_wb_sel),
    .writes  (dec_writes),
    .legal   (dec_legal),
    .is_halt (dec_is_halt)
  );

  always_comb begin
    load = (state_q == FETCH) && instr_valid;
    ir_d = load ? instr_data : ir_q;

    fld_d.dest    = dec_dest;
    fld_d.src0    = dec_src0;
    fld_d.src1    = dec_src1;
    fld_d.alu_op  = dec_alu_op;
    fld_d.imm     = dec_imm;
    fld_d.wb_sel  = dec_wb_sel;
    fld_d.writes  = dec_writes;
    fld_d.legal   = dec_legal;
    fld_d.is_halt = dec_is_halt;

    state_d   = state_q;
    pc_d      = pc_q;
    w_en_d    = 1'b0;
    illegal_d = 1'b0;

    case (state_q)
      FETCH: begin
        if (load) begin
          state_d   = DECODE;
          illegal_d = !dec_legal;
        end
      end
      DECODE: begin
        if (fld_q.is_halt || (!fld_q.legal && ILLEGAL_HALT)) begin
          state_d = HALT;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = WB;
        w_en_d  = fld_q.writes;
      end
      WB: begin
        state_d = FETCH;
        pc_d    = pc_q + 16'd1;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    // Status outputs are registered views of the state being entered.
    halted_d    = (state_d == HALT);
    instr_req_d = (state_d == FETCH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= 16'h0000;
      fld_q       <= FIELDS_NOP;
      w_en_q      <= 1'b0;
      illegal_q   <= 1'b0;
      halted_q    <= 1'b0;
      instr_req_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      fld_q       <= fld_d;
      w_en_q      <= w_en_d;
      illegal_q   <= illegal_d;
      halted_q    <= halted_d;
      instr_req_q <= instr_req_d;
    end
  end

  always_comb begin
    instr_req  = instr_req_q;
    instr_addr = pc_q;
    pc         = pc_q;
    dest       = fld_q.dest;
    src0       = fld_q.src0;
    src1       = fld_q.src1;
    alu_op     = fld_q.alu_op;
    imm        = fld_q.imm;
    wb_sel     = fld_q.wb_sel;
    w_en       = w_en_q;
    halted     = halted_q;
    illegal    = illegal_q;
  end

endmodule

// File: tb/tb_decode_ctrl.sv
// Self-checking bench for decode_ctrl: hand-written vector table, directed
// multi-cycle sequences and randomized instructions against a behavioural model.
module tb_decode_ctrl;

  typedef struct {
    logic [15:0] instr;
    logic [2:0]  dest;
    logic [2:0]  src0;
    logic [2:0]  src1;
    logic [2:0]  alu_op;
    logic [15:0] imm;
    logic        wb_sel;
    logic        wen;
    logic        illegal;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic [15:0] instr_data = 16'h0000;

  // Instance a: defaults; h: ILLEGAL_HALT=1; w: RESET_PC=16'hFFFF.
  logic        req_a, wen_a, wbsel_a, halted_a, illegal_a;
  logic [15:0] addr_a, imm_a, pc_a;
  logic [2:0]  dest_a, src0_a, src1_a, aluop_a;
  logic        req_h, wen_h, wbsel_h, halted_h, illegal_h;
  logic [15:0] addr_h, imm_h, pc_h;
  logic [2:0]  dest_h, src0_h, src1_h, aluop_h;
  logic        req_w, wen_w, wbsel_w, halted_w, illegal_w;
  logic [15:0] addr_w, imm_w, pc_w;
  logic [2:0]  dest_w, src0_w, src1_w, aluop_w;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_pc = 16'h0000;

  always #5 clk = ~clk;

  decode_ctrl dut (
    .clk(clk), .reset(reset), .instr_req(req_a), .instr_addr(addr_a),
    .instr_valid(instr_valid), .instr_data(instr_data), .dest(dest_a),
    .src0(src0_a), .src1(src1_a), .w_en(wen_a), .wb_sel(wbsel_a),
    .alu_op(aluop_a), .imm(imm_a), .pc(pc_a), .halted(halted_a),
    .illegal(illegal_a)
  );

  decode_ctrl #(.ILLEGAL_HALT(1'b1)) dut_h (
    .clk(clk), .reset(reset), .instr_req(req_h), .instr_addr(addr_h),
    .instr_valid(instr_valid), .instr_data(instr_data), .dest(dest_h),
    .src0(src0_h), .src1(src1_h), .w_en(wen_h), .wb_sel(wbsel_h),
    .alu_op(aluop_h), .imm(imm_h), .pc(pc_h), .halted(halted_h),
    .illegal(illegal_h)
  );

  decode_ctrl #(.RESET_PC(16'hFFFF)) dut_w (
    .clk(clk), .reset(reset), .instr_req(req_w), .instr_addr(addr_w),
    .instr_valid(instr_valid), .instr_data(instr_data), .dest(dest_w),
    .src0(src0_w), .src1(src1_w), .w_en(wen_w), .wb_sel(wbsel_w),
    .alu_op(aluop_w), .imm(imm_w), .pc(pc_w), .halted(halted_w),
    .illegal(illegal_w)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] i, input logic [2:0] d, input logic [2:0] s0,
                              input logic [2:0] s1, input logic [2:0] op, input logic [15:0] im,
                              input logic ws, input logic we, input logic il);
    vec_t v;
    v.instr = i; v.dest = d; v.src0 = s0; v.src1 = s1; v.alu_op = op;
    v.imm = im; v.wb_sel = ws; v.wen = we; v.illegal = il;
    return v;
  endfunction

  // Reference: expected architectural outputs straight from the ISA rules.
  function automatic vec_t model(input logic [15:0] i);
    vec_t v;
    int   op;
    op = int'(i[15:12]);
    v.instr   = i;
    v.dest    = i[11:9];
    v.src0    = i[8:6];
    v.src1    = i[5:3];
    v.imm     = 16'(i % 512);
    v.wen     = (op >= 1 && op <= 3);
    v.wb_sel  = (op == 2);
    v.alu_op  = (op == 1) ? i[2:0] : (op == 3) ? 3'd7 : 3'd0;
    v.illegal = !(op <= 3 || op == 15);
    return v;
  endfunction

  task automatic chk_fields(input string tag, input vec_t v);
    check({tag, "_dest"},   dest_a,  v.dest);
    check({tag, "_src0"},   src0_a,  v.src0);
    check({tag, "_src1"},   src1_a,  v.src1);
    check({tag, "_alu_op"}, aluop_a, v.alu_op);
    check({tag, "_imm"},    imm_a,   v.imm);
    check({tag, "_wb_sel"}, wbsel_a, v.wb_sel);
  endtask

  task automatic do_reset();
    @(negedge clk);
    instr_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_req", req_a, 1);
    check("rst_wen", wen_a, 0);
    check("rst_illegal", illegal_a, 0);
    check("rst_halted", halted_a, 0);
    check("rst_pc", pc_a, 16'h0000);
    check("rst_addr", addr_a, 16'h0000);
    check("rst_fields", {dest_a, src0_a, src1_a, aluop_a, imm_a, wbsel_a}, 0);
    check("rst_pc_w", pc_w, 16'hFFFF);
    @(negedge clk);
    reset = 1'b0;
    exp_pc = 16'h0000;
  endtask

  // Entered at a negedge in FETCH; leaves at the negedge of the next FETCH.
  task automatic run_instr(input vec_t v, input bit first);
    bit is_halt;
    is_halt = (v.instr[15:12] == 4'hF);
    check("fetch_req", req_a, 1);
    check("fetch_addr", addr_a, exp_pc);
    instr_valid = 1'b1;
    instr_data  = v.instr;
    @(negedge clk);
    instr_data = 16'($urandom);
    chk_fields("dec", v);
    check("dec_illegal", illegal_a, v.illegal);
    check("dec_wen", wen_a, 0);
    check("dec_req", req_a, 0);
    if (first) check("h_dec_illegal", illegal_h, v.illegal);
    @(negedge clk);
    instr_data = 16'($urandom);
    if (first) check("h_halted", halted_h, v.illegal || is_halt);
    if (is_halt) begin
      check("halt_halted", halted_a, 1);
      check("halt_req", req_a, 0);
      check("halt_wen", wen_a, 0);
      check("halt_pc", pc_a, exp_pc);
      if (first) check("w_halt_pc", pc_w, 16'hFFFF);
      instr_valid = 1'b0;
      return;
    end
    chk_fields("exec", v);
    check("exec_illegal", illegal_a, 0);
    check("exec_wen", wen_a, 0);
    check("exec_halted", halted_a, 0);
    check("exec_pc", pc_a, exp_pc);
    @(negedge clk);
    instr_data = 16'($urandom);
    chk_fields("wb", v);
    check("wb_wen", wen_a, v.wen);
    check("wb_pc", pc_a, exp_pc);
    @(negedge clk);
    instr_valid = 1'b0;
    exp_pc = exp_pc + 16'd1;
    chk_fields("post", v);
    check("post_wen", wen_a, 0);
    check("post_pc", pc_a, exp_pc);
    check("post_req", req_a, 1);
    if (first) check("w_wrap_pc", pc_w, 16'h0000);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[6];
    tbl[0] = mk(16'h1253, 3'd1, 3'd1, 3'd2, 3'd3, 16'h0053, 1'b0, 1'b1, 1'b0);
    tbl[1] = mk(16'h25FF, 3'd2, 3'd7, 3'd7, 3'd0, 16'h01FF, 1'b1, 1'b1, 1'b0);
    tbl[2] = mk(16'h0000, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    tbl[3] = mk(16'h7000, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1);
    tbl[4] = mk(16'h3A80, 3'd5, 3'd2, 3'd0, 3'd7, 16'h0080, 1'b0, 1'b1, 1'b0);
    tbl[5] = mk(16'h1FFF, 3'd7, 3'd7, 3'd7, 3'd7, 16'h01FF, 1'b0, 1'b1, 1'b0);

    do_reset();
    for (int i = 0; i < 6; i++) run_instr(tbl[i], i == 0);

    // NOP then HALT: no writes, halted at pc=1, further fetches ignored.
    do_reset();
    run_instr(tbl[2], 1'b1);
    run_instr(mk(16'hF000, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0), 1'b0);
    for (int i = 0; i < 6; i++) begin
      instr_valid = 1'b1;
      instr_data  = 16'h1253;
      @(negedge clk);
      check("hold_halted", halted_a, 1);
      check("hold_req", req_a, 0);
      check("hold_wen", wen_a, 0);
      check("hold_pc", pc_a, 16'h0001);
      check("hold_dest", dest_a, 0);
    end
    instr_valid = 1'b0;

    // Undefined opcode as the first instruction: instance h must halt.
    do_reset();
    run_instr(tbl[3], 1'b1);

    // Long fetch wait, then a NOP (also wraps instance w from FFFF to 0000).
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("wait_req", req_a, 1);
      check("wait_pc", pc_a, 16'h0000);
      check("wait_wen", wen_a, 0);
      check("wait_illegal", illegal_a, 0);
      check("wait_halted", halted_a, 0);
    end
    run_instr(tbl[2], 1'b1);

    // Reset asserted in the middle of the WB cycle of an LDI.
    do_reset();
    run_instr(tbl[0], 1'b0);
    instr_valid = 1'b1;
    instr_data  = 16'h25FF;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_wb_wen_before", wen_a, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_wb_wen_after", wen_a, 0);
    check("mid_wb_pc", pc_a, 16'h0000);
    check("mid_wb_req", req_a, 1);
    check("mid_wb_dest", dest_a, 0);
    @(negedge clk);
    reset = 1'b0;
    exp_pc = 16'h0000;
    run_instr(tbl[4], 1'b0);

    // Randomized instruction stream (never HALT) against the model.
    do_reset();
    for (int i = 0; i < 60; i++) begin
      logic [3:0]  op;
      logic [15:0] ins;
      if ($urandom_range(0, 5) < 4) op = 4'($urandom_range(0, 3));
      else                          op = 4'($urandom_range(4, 14));
      ins = {op, 12'($urandom)};
      run_instr(model(ins), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
